x_wave_player: RTL and testbench

Parametrised multi-channel sample sequencer for the DAC path. Reads sample words from the sample memory's dedicated synchronous read port at a programmable rate and presents one binary code per channel to the `x_bin_to_therm` instances. It supports one-shot and loop playback over an arbitrary address window, including windows that wrap past the top of memory. It sits between `x_mem` and the binary-to-thermometer converters and is configured and triggered by `x_ctrl`.

---
 rtl/x_wave_pkg.sv | 19 +
 rtl/x_rate_div.sv | 44 ++++
 rtl/x_wave_player.sv | 206 ++++++++++++++++++++
 tb/tb_x_wave_player.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_wave_pkg.sv
// -----------------------------------------------------------------------------
// x_wave_pkg
// Shared definitions for the wave player: the sequencer state type and the
// smallest usable rate divider. The sequencer needs one cycle to issue a
// prefetch and one cycle to capture the data before the next update, so
// periods shorter than three cycles cannot be sustained.
// -----------------------------------------------------------------------------
package x_wave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } wave_state_t;

    localparam int WAVE_DIV_MIN = 2;

endpackage

// File: rtl/x_rate_div.sv
// -----------------------------------------------------------------------------
// x_rate_div
// Loadable down-counter that paces sample updates.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : force the count to zero (wins over load)
//   load        : load load_val this cycle
//   load_val    : reload value (period - 1)
//   tc          : count is zero (terminal count)
//   load_cycle  : count was loaded on the previous edge, i.e. the first
//                 cycle of a new period
// -----------------------------------------------------------------------------
module x_rate_div #(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    output logic            tc,
    output logic            load_cycle
);

    logic [DIVW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            load_cycle <= 1'b0;
        end else begin
            load_cycle <= load & ~clear;
            if (clear) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - DIVW'(1);
            end
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/x_wave_player.sv
// -----------------------------------------------------------------------------
// x_wave_player
// Multi-channel sample sequencer. Plays an address window of the sample
// memory at a programmable rate, one-shot or looping, and drives one binary
// code per channel towards the thermometer converters.
//   i_clk, i_nrst        : clock, asynchronous active-low reset
//   i_start / i_stop     : single-cycle control pulses (stop wins)
//   i_loop               : 1 = loop the window, 0 = play it once
//   i_start_addr/end_addr: inclusive window, may wrap past the top of memory
//   i_div                : sample period is i_div+1 cycles (minimum 3)
//   o_re, o_addr         : synchronous memory read port, data on i_rdata
//                          one cycle later
//   o_bin                : current codes, channel 0 in the low DW bits
//   o_sample_stb         : first cycle of each new o_bin value
//   o_busy, o_done       : playback active / one-shot completion pulse
// -----------------------------------------------------------------------------
module x_wave_player
    import x_wave_pkg::*;
#(
    parameter int DW   = 6,
    parameter int AW   = 11,
    parameter int CH   = 1,
    parameter int DIVW = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_loop,
    input  logic [AW-1:0]    i_start_addr,
    input  logic [AW-1:0]    i_end_addr,
    input  logic [DIVW-1:0]  i_div,
    output logic             o_re,
    output logic [AW-1:0]    o_addr,
    input  logic [CH*DW-1:0] i_rdata,
    output logic [CH*DW-1:0] o_bin,
    output logic             o_sample_stb,
    output logic             o_busy,
    output logic             o_done
);

    wave_state_t       state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     start_r;
    logic [AW-1:0]     end_r;
    logic [DIVW-1:0]   div_r;
    logic              loop_r;
    logic              last;      // final window address has been issued
    logic              cap;       // i_rdata carries the prefetched word
    logic              hold_vld;
    logic [CH*DW-1:0]  hold;

    logic              cnt_clear;
    logic              cnt_load;
    logic              tc;
    logic              load_cycle;

    // Divider values below the minimum saturate to the minimum.
    function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] d);
        if (d < DIVW'(WAVE_DIV_MIN)) begin
            return DIVW'(WAVE_DIV_MIN);
        end
        return d;
    endfunction

    // Next pointer after issuing 'cur', with the last flag in the MSB.
    // The increment wraps modulo 2^AW so windows may cross the top of memory.
    function automatic logic [AW:0] advance(input logic [AW-1:0] cur,
                                            input logic [AW-1:0] last_a,
                                            input logic [AW-1:0] first_a,
                                            input logic          lp);
        logic [AW:0] r;
        r = {1'b0, cur + AW'(1)};
        if (cur == last_a) begin
            r = lp ? {1'b0, first_a} : {1'b1, cur};
        end
        return r;
    endfunction

    // Reload at FILL and at every update; the one-shot completion cycle
    // leaves the counter at zero for IDLE.
    always_comb begin
        cnt_clear = i_stop | i_start;
        cnt_load  = 1'b0;
        if (!cnt_clear) begin
            if (state == ST_FILL) begin
                cnt_load = 1'b1;
            end else if (state == ST_RUN && tc && (hold_vld || !last)) begin
                cnt_load = 1'b1;
            end
        end
    end

    x_rate_div #(
        .DIVW(DIVW)
    ) u_rate_div (
        .clk        (i_clk),
        .rst_n      (i_nrst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_val   (div_r),
        .tc         (tc),
        .load_cycle (load_cycle)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            start_r      <= '0;
            end_r        <= '0;
            div_r        <= DIVW'(WAVE_DIV_MIN);
            loop_r       <= 1'b0;
            last         <= 1'b0;
            cap          <= 1'b0;
            hold_vld     <= 1'b0;
            o_re         <= 1'b0;
            o_addr       <= '0;
            o_bin        <= '0;
            o_sample_stb <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_re         <= 1'b0;
            o_sample_stb <= 1'b0;
            o_done       <= 1'b0;
            // The read issued in the first cycle of a period returns now.
            cap          <= o_re & load_cycle & (state == ST_RUN);

            if (i_stop) begin
                // Abort: drop any in-flight read, keep o_bin as it is.
                state    <= ST_IDLE;
                o_busy   <= 1'b0;
                last     <= 1'b0;
                cap      <= 1'b0;
                hold_vld <= 1'b0;
            end else if (i_start) begin
                // (Re)start: the first read goes out directly from here.
                start_r     <= i_start_addr;
                end_r       <= i_end_addr;
                div_r       <= clamp_div(i_div);
                loop_r      <= i_loop;
                state       <= ST_PRIME;
                o_busy      <= 1'b1;
                o_re        <= 1'b1;
                o_addr      <= i_start_addr;
                {last, ptr} <= advance(i_start_addr, i_end_addr, i_start_addr, i_loop);
                cap         <= 1'b0;
                hold_vld    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_PRIME: begin
                        state <= ST_FILL;
                    end
                    ST_FILL: begin
                        o_bin        <= i_rdata;
                        o_sample_stb <= 1'b1;
                        state        <= ST_RUN;
                        if (!last) begin
                            o_re        <= 1'b1;
                            o_addr      <= ptr;
                            {last, ptr} <= advance(ptr, end_r, start_r, loop_r);
                        end
                    end
                    ST_RUN: begin
                        if (cap) begin
                            hold_vld <= 1'b1;
                        end
                        if (tc) begin
                            if (hold_vld) begin
                                o_bin        <= hold;
                                o_sample_stb <= 1'b1;
                                hold_vld     <= 1'b0;
                                if (!last) begin
                                    o_re        <= 1'b1;
                                    o_addr      <= ptr;
                                    {last, ptr} <= advance(ptr, end_r, start_r, loop_r);
                                end
                            end else if (last) begin
                                // Final sample has had its full period.
                                state  <= ST_IDLE;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                last   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Prefetch holding register; qualified by hold_vld, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (cap) begin
            hold <= i_rdata;
        end
    end

endmodule

// File: tb/tb_x_wave_player.sv
// -----------------------------------------------------------------------------
// tb_x_wave_player
// Self-checking bench for x_wave_player (CH=4, DW=6, AW=11). A synchronous
// memory model answers the read port; each cycle the expected outputs are
// computed arithmetically from the playback rules (start latency, period,
// window length and address wrap) and compared with the DUT.
// -----------------------------------------------------------------------------
module tb_x_wave_player;

    localparam int DW    = 6;
    localparam int AW    = 11;
    localparam int CH    = 4;
    localparam int DIVW  = 16;
    localparam int WW    = CH * DW;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            nrst;
    logic            start;
    logic            stop;
    logic            loop_en;
    logic [AW-1:0]   start_addr;
    logic [AW-1:0]   end_addr;
    logic [DIVW-1:0] div;
    logic            re;
    logic [AW-1:0]   addr;
    logic [WW-1:0]   rdata;
    logic [WW-1:0]   bin;
    logic            stb;
    logic            busy;
    logic            done;

    logic [WW-1:0]   mem [DEPTH];

    int n_total = 0;
    int n_bad   = 0;

    // model configuration of the current playback
    int            cfg_start;
    int            cfg_n;
    int            cfg_p;
    bit            cfg_loop;
    logic [WW-1:0] bin_before;
    logic [WW-1:0] exp_bin;

    x_wave_player #(
        .DW  (DW),
        .AW  (AW),
        .CH  (CH),
        .DIVW(DIVW)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_start      (start),
        .i_stop       (stop),
        .i_loop       (loop_en),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .i_div        (div),
        .o_re         (re),
        .o_addr       (addr),
        .i_rdata      (rdata),
        .o_bin        (bin),
        .o_sample_stb (stb),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rdata <= mem[addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int i);
        return (cfg_start + (i % cfg_n)) % DEPTH;
    endfunction

    // Expected outputs in cycle c after the start edge (c = 1 is T+1).
    task automatic check_cycle(input int c, input int stop_at);
        bit            e_busy, e_done, e_stb, e_re;
        int            e_addr, k, c_done;
        logic [WW-1:0] e_bin;
        e_busy = 0; e_done = 0; e_stb = 0; e_re = 0; e_addr = 0;
        e_bin  = exp_bin;
        c_done = 3 + cfg_n * cfg_p;
        if ((stop_at == 0 || c <= stop_at) && (cfg_loop || c <= c_done)) begin
            e_busy = cfg_loop || (c < c_done);
            e_done = !cfg_loop && (c == c_done);
            if (c == 1) begin
                e_re   = 1;
                e_addr = addr_of(0);
            end
            if (c < 3) begin
                e_bin = bin_before;
            end else begin
                k = (c - 3) / cfg_p;
                if ((c - 3) % cfg_p == 0 && (cfg_loop || k < cfg_n)) e_stb = 1;
                if ((c - 3) % cfg_p == 0 && (cfg_loop || k + 1 < cfg_n)) begin
                    e_re   = 1;
                    e_addr = addr_of(k + 1);
                end
                if (!cfg_loop && k > cfg_n - 1) k = cfg_n - 1;
                e_bin = mem[addr_of(k)];
            end
        end
        exp_bin = e_bin;
        chk($sformatf("busy@%0d", c), 64'(busy), 64'(e_busy));
        chk($sformatf("done@%0d", c), 64'(done), 64'(e_done));
        chk($sformatf("stb@%0d", c),  64'(stb),  64'(e_stb));
        chk($sformatf("re@%0d", c),   64'(re),   64'(e_re));
        chk($sformatf("bin@%0d", c),  64'(bin),  64'(e_bin));
        if (e_re) chk($sformatf("addr@%0d", c), 64'(addr), 64'(e_addr));
    endtask

    // Starts a playback in the current cycle and checks cycles 1..ncyc+1.
    // stop_at != 0 pulses i_stop in that cycle (with i_start too if both).
    task automatic play(input int st, input int en, input int dv, input bit lp,
                        input int ncyc, input int stop_at, input bit both);
        cfg_start  = st;
        cfg_n      = ((en - st) % DEPTH + DEPTH) % DEPTH + 1;
        cfg_p      = ((dv < 2) ? 2 : dv) + 1;
        cfg_loop   = lp;
        bin_before = exp_bin;
        start      = 1'b1;
        start_addr = AW'(st);
        end_addr   = AW'(en);
        div        = DIVW'(dv);
        loop_en    = lp;
        @(negedge clk);
        start      = 1'b0;
        // config changes during playback must be ignored
        start_addr = AW'($urandom);
        end_addr   = AW'($urandom);
        div        = DIVW'($urandom_range(0, 9));
        loop_en    = 1'($urandom);
        for (int c = 1; c <= ncyc; c++) begin
            check_cycle(c, stop_at);
            if (c == stop_at) begin
                stop       = 1'b1;
                start      = both;
                start_addr = AW'($urandom);
            end
            @(negedge clk);
            stop  = 1'b0;
            start = 1'b0;
        end
        check_cycle(ncyc + 1, stop_at);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_re"},   64'(re),   64'd0);
        chk({tag, "_addr"}, 64'(addr), 64'd0);
        chk({tag, "_bin"},  64'(bin),  64'd0);
        chk({tag, "_stb"},  64'(stb),  64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int st, len, dv, ncyc, stp;
        bit lp;
        for (int i = 0; i < DEPTH; i++) mem[i] = WW'($urandom);
        nrst = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0; div = '0;
        exp_bin = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        nrst = 1'b1;
        @(negedge clk);

        // one-shot 5,10,20,40: strobes at 3,8,13,18, done at 23
        mem[0] = WW'(5); mem[1] = WW'(10); mem[2] = WW'(20); mem[3] = WW'(40);
        play(0, 3, 4, 0, 30, 0, 0);
        chk("oneshot_hold", 64'(bin), 64'd40);

        // looping window wrapping past the top of memory
        play(2046, 1, 3, 1, 51, 50, 0);

        // div=0 and div=1 clamp to a 3-cycle period
        play(100, 104, 0, 0, 25, 0, 0);
        play(10, 12, 1, 1, 30, 28, 0);

        // stop in the cycle after a prefetch read (prefetch at c=9)
        play(200, 207, 5, 0, 30, 10, 0);

        // restart while busy, then start+stop together while busy
        play(300, 303, 3, 1, 20, 0, 0);
        play(8, 11, 2, 1, 20, 0, 0);
        play(50, 60, 4, 1, 25, 12, 1);

        // randomized playbacks
        for (int r = 0; r < 10; r++) begin
            st   = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(1, 5));
            dv   = int'($urandom_range(0, 6));
            lp   = 1'($urandom);
            ncyc = lp ? 3 + 3 * len * (((dv < 2) ? 2 : dv) + 1)
                      : 3 + len * (((dv < 2) ? 2 : dv) + 1) + 4;
            stp  = lp ? ncyc - 2 : (($urandom_range(0, 2) == 0) ? int'($urandom_range(2, ncyc - 3)) : 0);
            play(st, (st + len - 1) % DEPTH, dv, lp, ncyc, stp, 0);
        end

        // channel packing, then asynchronous reset while running
        mem[400] = 24'h00FC30;
        play(400, 401, 2, 1, 10, 0, 0);
        chk("ch0", 64'(bin[5:0]),   64'd48);
        chk("ch1", 64'(bin[11:6]),  64'd48);
        chk("ch2", 64'(bin[17:12]), 64'd15);
        chk("ch3", 64'(bin[23:18]), 64'd0);
        #2 nrst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        nrst    = 1'b1;
        exp_bin = '0;

        // recovery after reset
        play(0, 3, 4, 0, 26, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
